// File: rtl/async_reset_shift_reg_pkg.sv
// Shared helpers for the async-reset shift register: counter widths and default reset value.
package async_reset_pkg;

  localparam logic DEFAULT_RESET_BIT = 1'b0;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/async_reset_shift_reg_stage.sv
// One WIDTH-bit register stage with asynchronous reset, synchronous clear and enable.
module async_reset_stage
  import async_reset_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Stage register: clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VALUE;
    end else if (clr) begin
      data_q <= RESET_VALUE;
    end else if (en) begin
      data_q <= d;
    end else begin
      data_q <= data_q;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/async_reset_shift_reg.sv
// DEPTH-stage async-reset pipeline with fill tracking (q_valid).
// Optional settle detector (q_stable) enabled by defining ASYNC_RESET_SHIFT_REG_STABLE_EN.
module async_reset_shift_reg
  import async_reset_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
`ifdef ASYNC_RESET_SHIFT_REG_STABLE_EN
  ,
  parameter int               STABLE_CNT  = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
`ifdef ASYNC_RESET_SHIFT_REG_STABLE_EN
  ,
  output logic             q_stable
`endif
);

  localparam int              FILL_W   = cnt_w(DEPTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [WIDTH-1:0] stage_in_s  [DEPTH];
  logic [WIDTH-1:0] stage_out_s [DEPTH];

  logic [FILL_W-1:0] fill_cnt_q;
  logic [FILL_W-1:0] fill_cnt_d;
  logic              valid_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in_s[i] = d;
    end else begin : g_link
      assign stage_in_s[i] = stage_out_s[i-1];
    end

    async_reset_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (sync_clr),
      .d   (stage_in_s[i]),
      .q   (stage_out_s[i])
    );
  end

  assign q = stage_out_s[DEPTH-1];

  // Fill counter next state: saturates at DEPTH so q_valid never drops while shifting.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (sync_clr) begin
      fill_cnt_d = '0;
    end else if (en && (fill_cnt_q != FILL_MAX)) begin
      fill_cnt_d = fill_cnt_q + FILL_W'(1);
    end else begin
      fill_cnt_d = fill_cnt_q;
    end
  end

  // Fill counter and registered valid flag, updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= (fill_cnt_d == FILL_MAX);
    end
  end

  assign q_valid = valid_q;

`ifdef ASYNC_RESET_SHIFT_REG_STABLE_EN
  localparam int              STAB_W   = cnt_w(STABLE_CNT);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);

  logic [STAB_W-1:0] stab_cnt_q;
  logic [STAB_W-1:0] stab_cnt_d;
  logic              stable_q;

  // stage_in_s[DEPTH-1] is the value q takes on the coming enabled edge.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (sync_clr) begin
      stab_cnt_d = '0;
    end else if (en) begin
      if (stage_in_s[DEPTH-1] != q) begin
        stab_cnt_d = '0;
      end else if (stab_cnt_q != STAB_MAX) begin
        stab_cnt_d = stab_cnt_q + STAB_W'(1);
      end else begin
        stab_cnt_d = stab_cnt_q;
      end
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
  end

  // Stability counter and registered q_stable flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt_q <= '0;
      stable_q   <= 1'b0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      stable_q   <= (fill_cnt_d == FILL_MAX) && (stab_cnt_d == STAB_MAX);
    end
  end

  assign q_stable = stable_q;
`endif

endmodule

// File: tb/tb_async_reset_shift_reg.sv
// Scoreboard bench for async_reset_shift_reg (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
// q_stable is checked only when ASYNC_RESET_SHIFT_REG_STABLE_EN is defined.
module tb_async_reset_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       sync_clr = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       q_valid;
`ifdef ASYNC_RESET_SHIFT_REG_STABLE_EN
  logic       q_stable;
`endif

  typedef struct {
    logic [7:0] q;
    logic       v;
    logic       s;
    bit         cs;
    string      name;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  async_reset_shift_reg #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .d        (d),
    .q        (q),
    .q_valid  (q_valid)
`ifdef ASYNC_RESET_SHIFT_REG_STABLE_EN
    ,
    .q_stable (q_stable)
`endif
  );

  // Monitor: outputs are sampled on the falling edge or right after an async reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ((q !== e.q) || (q_valid !== e.v)) begin
          bad++;
          $display("FAIL %s: got q=%h q_valid=%b, expected q=%h q_valid=%b",
                   e.name, q, q_valid, e.q, e.v);
        end
`ifdef ASYNC_RESET_SHIFT_REG_STABLE_EN
        if (e.cs) begin
          total++;
          if (q_stable !== e.s) begin
            bad++;
            $display("FAIL %s_stable: got q_stable=%b, expected %b", e.name, q_stable, e.s);
          end
        end
`endif
      end
    end
  end

  task automatic step(input logic r, input logic e_en, input logic clr, input logic [7:0] din,
                      input logic [7:0] eq, input logic ev, input logic es, input bit cs,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; en = e_en; sync_clr = clr; d = din;
    @(posedge clk);
    e.q = eq; e.v = ev; e.s = es; e.cs = cs; e.name = nm;
    sb.push_back(e);
  endtask

  // Assert rst between clock edges and check its effect before any edge.
  task automatic pulse_rst(input string nm);
    exp_t e;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    e.q = 8'hA5; e.v = 1'b0; e.s = 1'b0; e.cs = 1'b1; e.name = nm;
    sb.push_back(e);
    -> chk_ev;
  endtask

  initial begin
    exp_t e;
    // Async reset before the first clock edge.
    #2;
    rst = 1'b1;
    #1;
    e.q = 8'hA5; e.v = 1'b0; e.s = 1'b0; e.cs = 1'b1; e.name = "rst_async";
    sb.push_back(e);
    -> chk_ev;
    step(1'b1, 1'b1, 1'b0, 8'h12, 8'hA5, 1'b0, 1'b0, 1'b1, "rst_held");

    // Plain fill: latency of three enabled edges.
    step(1'b0, 1'b1, 1'b0, 8'h01, 8'hA5, 1'b0, 1'b0, 1'b0, "fill_e1");
    step(1'b0, 1'b1, 1'b0, 8'h02, 8'hA5, 1'b0, 1'b0, 1'b0, "fill_e2");
    step(1'b0, 1'b1, 1'b0, 8'h03, 8'h01, 1'b1, 1'b0, 1'b0, "fill_e3");
    step(1'b0, 1'b1, 1'b0, 8'h04, 8'h02, 1'b1, 1'b0, 1'b0, "fill_e4");

    // Enable gaps: data must hold while en=0.
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, "clr_idle");
    step(1'b0, 1'b1, 1'b0, 8'h11, 8'hA5, 1'b0, 1'b0, 1'b0, "gap_e1");
    step(1'b0, 1'b0, 1'b0, 8'hEE, 8'hA5, 1'b0, 1'b0, 1'b0, "gap_hold1");
    step(1'b0, 1'b1, 1'b0, 8'h22, 8'hA5, 1'b0, 1'b0, 1'b0, "gap_e2");
    step(1'b0, 1'b0, 1'b0, 8'hEE, 8'hA5, 1'b0, 1'b0, 1'b0, "gap_hold2");
    step(1'b0, 1'b1, 1'b0, 8'h33, 8'h11, 1'b1, 1'b0, 1'b0, "gap_e3");
    step(1'b0, 1'b0, 1'b0, 8'hEE, 8'h11, 1'b1, 1'b0, 1'b0, "gap_hold3");

    // sync_clr beats en on a full pipe; FF is dropped, stages refill from A5.
    step(1'b0, 1'b1, 1'b0, 8'h44, 8'h22, 1'b1, 1'b0, 1'b0, "full_shift");
    step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b0, "clr_wins");
    step(1'b0, 1'b1, 1'b0, 8'h55, 8'hA5, 1'b0, 1'b0, 1'b0, "post_clr1");
    step(1'b0, 1'b1, 1'b0, 8'h66, 8'hA5, 1'b0, 1'b0, 1'b0, "post_clr2");
    step(1'b0, 1'b1, 1'b0, 8'h77, 8'h55, 1'b1, 1'b0, 1'b0, "post_clr3");

    // Async reset mid-fill (fill=2), then a clean refill.
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, "clr_idle2");
    step(1'b0, 1'b1, 1'b0, 8'h81, 8'hA5, 1'b0, 1'b0, 1'b0, "mid_e1");
    step(1'b0, 1'b1, 1'b0, 8'h82, 8'hA5, 1'b0, 1'b0, 1'b0, "mid_e2");
    pulse_rst("rst_midfill");
    step(1'b0, 1'b1, 1'b0, 8'h91, 8'hA5, 1'b0, 1'b0, 1'b0, "refill_e1");
    step(1'b0, 1'b1, 1'b0, 8'h92, 8'hA5, 1'b0, 1'b0, 1'b0, "refill_e2");
    step(1'b0, 1'b1, 1'b0, 8'h93, 8'h91, 1'b1, 1'b0, 1'b0, "refill_e3");
    pulse_rst("rst_full");

    // Settling: constant 3C, then a single 3D passes through q.
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, "st_clr");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b1, "st_e1");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b1, "st_e2");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e3");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e4");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e5");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e6");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1, "st_e7");
    step(1'b0, 1'b1, 1'b0, 8'h3D, 8'h3C, 1'b1, 1'b1, 1'b1, "st_e8");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1, "st_e9");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3D, 1'b1, 1'b0, 1'b1, "st_e10");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e11");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e12");
    step(1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_hold");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e13");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, "st_e14");
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1, "st_e15");

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
